// File: rtl/spi_pkg.sv
// Shared types and constants for the configurable SPI master (spi_master_cfg).
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_e;

    // SPI modes encoded as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int DATA_W_MIN = 2;
    localparam int DATA_W_MAX = 32;
    localparam int NUM_CS_MIN = 1;
    localparam int NUM_CS_MAX = 8;
    localparam int DIV_MIN    = 1;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: a tick every DIV cycles while running, split into
// leading/trailing edge strobes by an alternating phase bit.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick,
    output logic lead,
    output logic trail
);
    localparam int CW = sel_width(DIV);

    logic [CW-1:0] cnt_r;
    logic          phase_r;

    // Strobe decode from the divider count and phase
    always_comb begin
        tick  = run && (cnt_r == CW'(DIV - 1));
        lead  = tick && !phase_r;
        trail = tick && phase_r;
    end

    // Divider counter and edge phase; idle clears both so every frame starts aligned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= '0;
            phase_r <= 1'b0;
        end else if (!run) begin
            cnt_r   <= '0;
            phase_r <= 1'b0;
        end else if (tick) begin
            cnt_r   <= '0;
            phase_r <= !phase_r;
        end else begin
            cnt_r   <= cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/spi_master_cfg.sv
// Configurable SPI master, modes 0-3, MSB first, one frame per request.
// Optional macro SPI_LOOPBACK_EN adds a loopback input that samples internal mosi.
module spi_master_cfg
    import spi_pkg::*;
#(
    parameter int  DATA_W = 8,
    parameter int  NUM_CS = 4,
    parameter int  DIV    = 2,
    localparam int CSW    = sel_width(NUM_CS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CSW-1:0]    cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    output logic [DATA_W-1:0] rx_data,
    output logic              done,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
`ifdef SPI_LOOPBACK_EN
    input  logic              loopback,
`endif
    output logic [NUM_CS-1:0] cs_n
);
    localparam int TCW = $clog2(2 * DATA_W + 1);

    spi_state_e        state_r, state_nxt_s;
    logic [TCW-1:0]    tick_cnt_r;
    logic [DATA_W-2:0] tx_rest_r;
    logic [DATA_W-1:0] rx_shift_r, rx_data_r;
    logic [NUM_CS-1:0] cs_n_r, cs_dec_s;
    logic              cpha_r, sclk_r, mosi_r, done_r;
    logic              run_s, tick_s, lead_s, trail_s, last_tick_s;
    logic              accept_s, edge_s, shift_s, sample_s, sample_bit_s;

    spi_clk_div #(.DIV(DIV)) u_clk_div (
        .clk   (clk),
        .rst   (rst),
        .run   (run_s),
        .tick  (tick_s),
        .lead  (lead_s),
        .trail (trail_s)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; tick count 2*DATA_W marks the end of the last half-period
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  if (start_valid) state_nxt_s = ST_SETUP; else state_nxt_s = ST_IDLE;
            ST_SETUP: if (tick_s) state_nxt_s = ST_XFER; else state_nxt_s = ST_SETUP;
            ST_XFER:  if (tick_s && last_tick_s) state_nxt_s = ST_HOLD; else state_nxt_s = ST_XFER;
            ST_HOLD:  if (tick_s) state_nxt_s = ST_IDLE; else state_nxt_s = ST_HOLD;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Output and strobe decode
    always_comb begin
        start_ready = (state_r == ST_IDLE);
        busy        = (state_r != ST_IDLE);
        run_s       = (state_r != ST_IDLE);
        accept_s    = start_valid && (state_r == ST_IDLE);
        last_tick_s = (tick_cnt_r == TCW'(2 * DATA_W));
        // SETUP's tick is leading edge 0; the tick closing XFER is not an SCLK edge
        edge_s      = tick_s && ((state_r == ST_SETUP) || ((state_r == ST_XFER) && !last_tick_s));
        shift_s     = edge_s && (cpha_r ? (lead_s && (tick_cnt_r != '0))
                                        : (trail_s && (tick_cnt_r != TCW'(2 * DATA_W - 1))));
        sample_s    = edge_s && (cpha_r ? trail_s : lead_s);
`ifdef SPI_LOOPBACK_EN
        sample_bit_s = loopback ? mosi_r : miso;
`else
        sample_bit_s = miso;
`endif
        cs_dec_s = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            cs_dec_s[i] = (cs_sel == CSW'(i)) ? 1'b0 : 1'b1;
        end
        rx_data = rx_data_r;
        done    = done_r;
        sclk    = sclk_r;
        mosi    = mosi_r;
        cs_n    = cs_n_r;
    end

    // Frame datapath: latch on accept, shift/sample on SCLK edges, publish at HOLD end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_r <= '0;
            tx_rest_r  <= '0;
            rx_shift_r <= '0;
            rx_data_r  <= '0;
            cs_n_r     <= '1;
            cpha_r     <= 1'b0;
            sclk_r     <= 1'b0;
            mosi_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept_s) begin
                tick_cnt_r <= '0;
                tx_rest_r  <= tx_data[DATA_W-2:0];
                mosi_r     <= tx_data[DATA_W-1];
                rx_shift_r <= '0;
                cs_n_r     <= cs_dec_s;
                cpha_r     <= cpha;
                sclk_r     <= cpol;
            end else begin
                if (edge_s) begin
                    sclk_r <= !sclk_r;
                end
                if (tick_s && (state_r != ST_HOLD)) begin
                    tick_cnt_r <= tick_cnt_r + TCW'(1);
                end
                if (shift_s) begin
                    mosi_r    <= tx_rest_r[DATA_W-2];
                    tx_rest_r <= tx_rest_r << 1;
                end
                if (sample_s) begin
                    rx_shift_r <= {rx_shift_r[DATA_W-2:0], sample_bit_s};
                end
                if (tick_s && (state_r == ST_HOLD)) begin
                    done_r    <= 1'b1;
                    rx_data_r <= rx_shift_r;
                    cs_n_r    <= '1;
                    mosi_r    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_master_cfg.sv
// Self-checking bench for spi_master_cfg: randomized frames against a slave model
// and a frame-level reference (expected rx word, done cycle, mosi stream).
module tb_spi_master_cfg;
`ifdef SPI_LOOPBACK_EN
    localparam int DW = 16;
`else
    localparam int DW = 8;
`endif
    localparam int NCS = 5;
    localparam int DV  = 2;
    localparam int CSW = 3;
    localparam int P   = 2 * DV * (DW + 1) + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start_valid = 1'b0;
    logic           cpol = 1'b0;
    logic           cpha = 1'b0;
    logic           miso = 1'b0;
    logic [DW-1:0]  tx_data = '0;
    logic [CSW-1:0] cs_sel = '0;
    logic           start_ready, done, busy, sclk, mosi;
    logic [DW-1:0]  rx_data;
    logic [NCS-1:0] cs_n;
`ifdef SPI_LOOPBACK_EN
    logic           loopback = 1'b0;
`endif

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    spi_master_cfg #(.DATA_W(DW), .NUM_CS(NCS), .DIV(DV)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .tx_data     (tx_data),
        .cs_sel      (cs_sel),
        .cpol        (cpol),
        .cpha        (cpha),
        .rx_data     (rx_data),
        .done        (done),
        .busy        (busy),
        .sclk        (sclk),
        .mosi        (mosi),
        .miso        (miso),
`ifdef SPI_LOOPBACK_EN
        .loopback    (loopback),
`endif
        .cs_n        (cs_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: counts SCLK edges, drives miso MSB first, captures mosi on its sample edges
    logic [DW-1:0] slave_word = '0;
    logic          cur_cpha = 1'b0;
    logic [DW-1:0] mosi_cap = '0, last_mosi = '0;
    int            edge_cnt = 0, cap_cnt = 0, last_cap = 0, idx = 0;
    logic          prev_sclk = 1'b0, prev_busy = 1'b0;

    always @(negedge clk) begin
        if (busy === 1'b1 && prev_busy === 1'b1) begin
            if (sclk !== prev_sclk) begin
                edge_cnt = edge_cnt + 1;
                if (((edge_cnt % 2) == 1) == (cur_cpha == 1'b0)) begin
                    mosi_cap = {mosi_cap[DW-2:0], mosi};
                    cap_cnt  = cap_cnt + 1;
                end
            end
        end else begin
            if (prev_busy === 1'b1) begin
                last_mosi = mosi_cap;
                last_cap  = cap_cnt;
            end
            edge_cnt = 0;
            cap_cnt  = 0;
            mosi_cap = '0;
        end
        if (cur_cpha) idx = (edge_cnt == 0) ? 0 : (edge_cnt - 1) / 2;
        else          idx = edge_cnt / 2;
        if (idx > DW - 1) idx = DW - 1;
        miso      = slave_word[DW-1-idx];
        prev_sclk = sclk;
        prev_busy = busy;
    end

    task automatic run_frame(input string tag, input logic [DW-1:0] tx, input logic [DW-1:0] slv,
                             input logic [CSW-1:0] cs, input logic pol, input logic pha, input logic lb);
        logic [NCS-1:0] exp_cs;
        logic [DW-1:0]  exp_rx;
        int  n, d;
        bit  cs_ok, got;
        exp_cs = '1;
        if (int'(cs) < NCS) exp_cs[cs] = 1'b0;
        exp_rx = lb ? tx : slv;
        slave_word = slv;
        cur_cpha   = pha;
        @(negedge clk); #1;
        tx_data = tx; cs_sel = cs; cpol = pol; cpha = pha; start_valid = 1'b1;
`ifdef SPI_LOOPBACK_EN
        loopback = lb;
`endif
        n = cyc;
        @(negedge clk); #1;
        start_valid = 1'b0; tx_data = DW'($urandom); cs_sel = CSW'($urandom); cpol = ~pol; cpha = ~pha;
        cs_ok = 1'b1; got = 1'b0; d = -1;
        for (int i = 0; i < 2 * P && !got; i++) begin
            if (done === 1'b1) begin
                got = 1'b1;
                d = cyc;
            end else begin
                if (busy !== 1'b1 || cs_n !== exp_cs) cs_ok = 1'b0;
                @(negedge clk); #1;
            end
        end
        checks++; if (d - n != P) $display("FAIL %s done_latency: got %0d, expected %0d", tag, d - n, P); else passed++;
        checks++; if (!cs_ok) $display("FAIL %s cs_n_frame: got mismatch, expected %b", tag, exp_cs); else passed++;
        checks++; if (rx_data !== exp_rx) $display("FAIL %s rx_data: got %h, expected %h", tag, rx_data, exp_rx); else passed++;
        checks++; if (last_mosi !== tx) $display("FAIL %s mosi_stream: got %h, expected %h", tag, last_mosi, tx); else passed++;
        checks++; if (last_cap != DW) $display("FAIL %s sample_count: got %0d, expected %0d", tag, last_cap, DW); else passed++;
        checks++; if (sclk !== pol) $display("FAIL %s sclk_idle: got %b, expected %b", tag, sclk, pol); else passed++;
        checks++; if (mosi !== 1'b0 || cs_n !== '1 || busy !== 1'b0)
            $display("FAIL %s idle_outputs: got mosi=%b cs_n=%b busy=%b, expected 0/all-ones/0", tag, mosi, cs_n, busy);
        else passed++;
        @(negedge clk); #1;
        checks++; if (done !== 1'b0 || rx_data !== exp_rx)
            $display("FAIL %s done_pulse_hold: got done=%b rx=%h, expected 0/%h", tag, done, rx_data, exp_rx);
        else passed++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++; if (cs_n !== '1) $display("FAIL reset_cs_n: got %b, expected all ones", cs_n); else passed++;
        checks++; if (sclk !== 1'b0 || mosi !== 1'b0) $display("FAIL reset_sclk_mosi: got %b%b, expected 00", sclk, mosi); else passed++;
        checks++; if (rx_data !== '0 || done !== 1'b0) $display("FAIL reset_rx_done: got %h/%b, expected 0/0", rx_data, done); else passed++;
        checks++; if (busy !== 1'b0 || start_ready !== 1'b1) $display("FAIL reset_busy_ready: got %b/%b, expected 0/1", busy, start_ready); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_modes_fixed();
        run_frame("mode0_a5", DW'(8'hA5), DW'(8'h3C), CSW'(0), 1'b0, 1'b0, 1'b0);
        run_frame("mode1_5a", DW'(8'h5A), DW'(8'hC3), CSW'(1), 1'b0, 1'b1, 1'b0);
        run_frame("mode2_5a", DW'(8'h5A), DW'(8'hC3), CSW'(3), 1'b1, 1'b0, 1'b0);
        run_frame("mode3_5a", DW'(8'h5A), DW'(8'hC3), CSW'(4), 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [1:0] m;
        for (int k = 0; k < 6; k++) begin
            m = 2'($urandom_range(0, 3));
            run_frame($sformatf("rand%0d", k), DW'($urandom), DW'($urandom),
                      CSW'($urandom_range(0, NCS - 1)), m[1], m[0], 1'b0);
        end
    endtask

    task automatic test_cs_select();
        run_frame("cs2", DW'($urandom), DW'($urandom), CSW'(2), 1'b0, 1'b0, 1'b0);
        run_frame("cs5_out_of_range", DW'($urandom), DW'($urandom), CSW'(5), 1'b1, 1'b0, 1'b0);
        run_frame("cs7_out_of_range", DW'($urandom), DW'($urandom), CSW'(7), 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] slv;
        int n, dones, hi;
        slv = DW'($urandom);
        slave_word = slv;
        cur_cpha = 1'b1;
        @(negedge clk); #1;
        tx_data = DW'($urandom); cs_sel = CSW'(3); cpol = 1'b0; cpha = 1'b1; start_valid = 1'b1;
        n = cyc; dones = 0; hi = 0;
        for (int i = 0; i < 4 * P && dones < 3; i++) begin
            @(negedge clk); #1;
            if (cs_n === '1) hi++;
            if (done === 1'b1) begin
                dones++;
                checks++; if (cyc - n != dones * P) $display("FAIL b2b_done_cycle: got %0d, expected %0d", cyc - n, dones * P); else passed++;
                checks++; if (rx_data !== slv) $display("FAIL b2b_rx_data: got %h, expected %h", rx_data, slv); else passed++;
                if (dones == 3) start_valid = 1'b0;
            end
        end
        start_valid = 1'b0;
        checks++; if (dones != 3) $display("FAIL b2b_frames: got %0d, expected 3", dones); else passed++;
        checks++; if (hi != 3) $display("FAIL b2b_cs_high_cycles: got %0d, expected 3", hi); else passed++;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL b2b_stop: got busy=%b, expected 0", busy); else passed++;
    endtask

    task automatic test_reset_midframe();
        bit seen;
        slave_word = DW'($urandom);
        cur_cpha = 1'b0;
        @(negedge clk); #1;
        tx_data = DW'($urandom); cs_sel = CSW'(1); cpol = 1'b1; cpha = 1'b0; start_valid = 1'b1;
        @(negedge clk); #1;
        start_valid = 1'b0;
        repeat (P / 2) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b, expected 1", busy); else passed++;
        #1; rst = 1'b1; #1;
        checks++; if (busy !== 1'b0 || start_ready !== 1'b1) $display("FAIL rstmid_busy: got %b/%b, expected 0/1", busy, start_ready); else passed++;
        checks++; if (cs_n !== '1) $display("FAIL rstmid_cs_n: got %b, expected all ones", cs_n); else passed++;
        checks++; if (sclk !== 1'b0 || mosi !== 1'b0) $display("FAIL rstmid_sclk_mosi: got %b%b, expected 00", sclk, mosi); else passed++;
        checks++; if (rx_data !== '0 || done !== 1'b0) $display("FAIL rstmid_rx_done: got %h/%b, expected 0/0", rx_data, done); else passed++;
        @(negedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2 * P; i++) begin
            @(negedge clk); #1;
            if (done === 1'b1) seen = 1'b1;
        end
        checks++; if (seen) $display("FAIL rstmid_no_done: got done pulse, expected none"); else passed++;
        checks++; if (rx_data !== '0) $display("FAIL rstmid_rx_hold: got %h, expected 0", rx_data); else passed++;
        run_frame("after_reset", DW'($urandom), DW'($urandom), CSW'(0), 1'b0, 1'b1, 1'b0);
    endtask

`ifdef SPI_LOOPBACK_EN
    task automatic test_loopback();
        run_frame("loopback_beef", DW'(16'hBEEF), '0, CSW'(0), 1'b0, 1'b0, 1'b1);
        run_frame("loopback_mode3", DW'($urandom), '0, CSW'(2), 1'b1, 1'b1, 1'b1);
    endtask
`endif

    initial begin
        test_reset();
        test_modes_fixed();
        test_random();
        test_cs_select();
        test_back_to_back();
        test_reset_midframe();
`ifdef SPI_LOOPBACK_EN
        test_loopback();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
